// File: rtl/uart_pattern_tx.sv
// uart_pattern_tx: pattern buffer replayed as back-to-back UART frames.
// Bytes are appended while idle, then played out rep_cnt times (0 = forever).

module uart_pattern_tx #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned REP_W        = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_BITS-1:0]       wr_data,
  input  logic                       clear,
  input  logic                       start,
  input  logic [REP_W-1:0]           rep_cnt,
  input  logic                       abort,
  output logic                       full,
  output logic                       busy,
  output logic                       done,
  output logic                       txd,
  output logic [$clog2(DEPTH)-1:0]   cur_idx
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned NW = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [CW-1:0]        count_q, count_n;

  state_t               state_q, state_n;
  logic [BW-1:0]        baud_q, baud_n;
  logic [NW-1:0]        bit_q, bit_n;
  logic [AW-1:0]        idx_n;
  logic [REP_W-1:0]     pass_q, pass_n;
  logic [REP_W-1:0]     rep_q, rep_n;
  logic [DATA_BITS-1:0] shreg_q, shreg_n;
  logic                 par_q, par_n;
  logic                 txd_n, busy_n, done_n;

  logic                 idle;
  logic                 start_ok, clear_ok, wr_ok;
  logic                 baud_last;
  logic                 last_entry;
  logic [AW-1:0]        next_idx;
  logic [REP_W-1:0]     pass_inc;
  logic                 done_cond;
  logic [DATA_BITS-1:0] next_byte;

  // Parity bit for one data word in the configured mode
  function automatic logic par_of(input logic [DATA_BITS-1:0] b);
    return (^b) ^ (PARITY == 2);
  endfunction

  // Request qualification and frame-boundary bookkeeping
  always_comb begin
    idle       = (state_q == IDLE);
    clear_ok   = clear && idle;
    start_ok   = start && !abort && !clear && idle && (count_q != '0);
    wr_ok      = wr_en && idle && !full && !start_ok && !clear;
    baud_last  = (baud_q == BW'(CLKS_PER_BIT - 1));
    last_entry = (cur_idx == AW'(count_q - CW'(1)));
    next_idx   = last_entry ? '0 : cur_idx + AW'(1);
    pass_inc   = pass_q + REP_W'(1);
    done_cond  = last_entry && (rep_q != '0) && (pass_inc == rep_q);
    next_byte  = mem[next_idx];
  end

  // Buffer fill level; clear wins over a same-cycle write
  always_comb begin
    count_n = count_q;
    if (clear_ok)   count_n = '0;
    else if (wr_ok) count_n = count_q + CW'(1);
  end

  // Fill-level registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      full    <= 1'b0;
    end else begin
      count_q <= count_n;
      full    <= (count_n == CW'(DEPTH));
    end
  end

  // Pattern storage; contents are invalidated by count, not cleared
  always_ff @(posedge clk) begin
    if (rst && wr_ok) mem[count_q[AW-1:0]] <= wr_data;
  end

  // Next-state and registered-output logic for the frame sequencer
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q + BW'(1);
    bit_n   = bit_q;
    idx_n   = cur_idx;
    pass_n  = pass_q;
    rep_n   = rep_q;
    shreg_n = shreg_q;
    par_n   = par_q;
    txd_n   = txd;
    busy_n  = busy;
    done_n  = 1'b0;

    case (state_q)
      IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        idx_n  = '0;
        txd_n  = 1'b1;
        busy_n = 1'b0;
        if (start_ok) begin
          state_n = START;
          pass_n  = '0;
          rep_n   = rep_cnt;
          shreg_n = mem[0];
          par_n   = par_of(mem[0]);
          txd_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (baud_last) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = '0;
          txd_n   = shreg_q[0];
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_q == NW'(DATA_BITS - 1)) begin
            bit_n = '0;
            if (PARITY != 0) begin
              state_n = PAR;
              txd_n   = par_q;
            end else begin
              state_n = STOP;
              txd_n   = 1'b1;
            end
          end else begin
            bit_n   = bit_q + NW'(1);
            shreg_n = shreg_q >> 1;
            txd_n   = shreg_q[1];
          end
        end
      end
      PAR: begin
        if (baud_last) begin
          state_n = STOP;
          baud_n  = '0;
          bit_n   = '0;
          txd_n   = 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_q == NW'(STOP_BITS - 1)) begin
            bit_n = '0;
            if (done_cond) begin
              state_n = IDLE;
              idx_n   = '0;
              txd_n   = 1'b1;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              state_n = START;
              idx_n   = next_idx;
              pass_n  = last_entry ? pass_inc : pass_q;
              shreg_n = next_byte;
              par_n   = par_of(next_byte);
              txd_n   = 1'b0;
            end
          end else begin
            bit_n = bit_q + NW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
        busy_n  = 1'b0;
      end
    endcase

    // Abort cuts the frame short without a done pulse
    if (abort && !idle) begin
      state_n = IDLE;
      baud_n  = '0;
      bit_n   = '0;
      idx_n   = '0;
      txd_n   = 1'b1;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end
  end

  // Sequencer state and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      cur_idx <= '0;
      pass_q  <= '0;
      rep_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      txd     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      cur_idx <= idx_n;
      pass_q  <= pass_n;
      rep_q   <= rep_n;
      shreg_q <= shreg_n;
      par_q   <= par_n;
      txd     <= txd_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule
